// File: rtl/run_controller.sv
// run_controller: load/run sequencer for the multicycle MIPS core.
// It streams a program image into the shared single-port memory while the
// core is held in reset. It then holds reset a few more cycles, runs the core
// until it stops or the cycle budget runs out, and owns the memory port mux.
//
// Loader handshake: a word moves when ld_valid && ld_ready at a rising clk
// edge. ld_ready is a registered flag that is high only in LOAD, so nothing on
// the loader inputs reaches ld_ready combinationally. ld_valid may drop for
// any number of cycles, and ld_data/ld_last are only looked at while ld_valid
// is high.
module run_controller #(
  parameter int MEM_WORDS = 256,
  parameter int RST_HOLD  = 2,
  parameter int TIMEOUT   = 100000,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_reset,
  input  logic [31:0]      cpu_memadd,
  input  logic [31:0]      cpu_outdata,
  input  logic             cpu_we,
  input  logic             cpu_stop,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             overflow,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       dbgState
);

  localparam int PTR_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(MEM_WORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    HALT  = 3'd4,
    ABORT = 3'd5
  } stateT;

  stateT             state;
  logic [PTR_W-1:0]  ptr;
  logic [HOLD_W-1:0] holdCnt;
  logic              transfer;

  assign transfer = ld_valid && ld_ready;
  assign dbgState = state;

  // Sequencer: state, load pointer, hold timer, run counter and status flags.
  // The status outputs are registered and updated on the same edge as the
  // state change that they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      holdCnt     <= '0;
      overflow    <= 1'b0;
      cycle_count <= '0;
      ld_ready    <= 1'b0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT, ABORT: begin
          if (start) begin
            state       <= LOAD;
            ptr         <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            abort       <= 1'b0;
            busy        <= 1'b1;
            ld_ready    <= 1'b1;
          end
        end
        LOAD: begin
          if (transfer) begin
            if (ld_last) begin
              state    <= HOLD;
              ld_ready <= 1'b0;
              holdCnt  <= '0;
            end else if (ptr == LAST_PTR) begin
              // Memory is full. The pointer stays on the top word, and every
              // later word is accepted but not written.
              overflow <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        HOLD: begin
          if (holdCnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          // A stop on the last budgeted cycle counts as a normal completion.
          if (cpu_stop) begin
            state     <= HALT;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (cycle_count == CNT_LIMIT) begin
            state     <= ABORT;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            abort     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          ld_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: the loader drives the port in LOAD, the core drives it in
  // RUN, and the port is parked (no write) in every other state.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      LOAD: begin
        mem_addr  = 32'(ptr) << 2;
        mem_wdata = ld_data;
        mem_we    = transfer && !overflow;
      end
      RUN: begin
        mem_addr  = cpu_memadd;
        mem_wdata = cpu_outdata;
        mem_we    = cpu_we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_run_controller.sv
// Testbench for run_controller: a table of per-cycle vectors plus directed
// sequences for timeout, loader gaps, stop-at-timeout and mid-run reset.
module tb_run_controller;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;
  localparam int NVEC = 22;

  typedef struct packed {
    logic        start;
    logic        ldValid;
    logic [31:0] ldData;
    logic        ldLast;
    logic [31:0] cpuMemadd;
    logic [31:0] cpuOutdata;
    logic        cpuWe;
    logic        cpuStop;
  } in_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        rdy;
    logic        crst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        abort;
    logic        ovf;
    logic [31:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_reset;
  logic [31:0] cpu_memadd;
  logic [31:0] cpu_outdata;
  logic        cpu_we;
  logic        cpu_stop;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        abort;
  logic        overflow;
  logic [31:0] cycle_count;
  logic [2:0]  dbgState;

  int testsRun;
  int testsFailed;

  vec_t vecs[NVEC];
  logic [63:0] exp_q[$];
  logic [63:0] wr_q[$];

  run_controller #(
    .MEM_WORDS(4),
    .RST_HOLD (2),
    .TIMEOUT  (50),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .cpu_reset  (cpu_reset),
    .cpu_memadd (cpu_memadd),
    .cpu_outdata(cpu_outdata),
    .cpu_we     (cpu_we),
    .cpu_stop   (cpu_stop),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .abort      (abort),
    .overflow   (overflow),
    .cycle_count(cycle_count),
    .dbgState   (dbgState)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write monitor: logs every memory write as {addr, data}
  always @(posedge clk) begin
    if (reset && mem_we) wr_q.push_back({mem_addr, mem_wdata});
  end

  function automatic in_t inp(input logic st, input logic v, input logic [31:0] d,
                              input logic l, input logic [31:0] ma,
                              input logic [31:0] od, input logic we, input logic sp);
    in_t r;
    r.start = st; r.ldValid = v; r.ldData = d; r.ldLast = l;
    r.cpuMemadd = ma; r.cpuOutdata = od; r.cpuWe = we; r.cpuStop = sp;
    return r;
  endfunction

  function automatic out_t outp(input logic [2:0] st, input logic rdy, input logic crst,
                                input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic b, input logic dn, input logic ab,
                                input logic ov, input logic [31:0] c);
    out_t r;
    r.st = st; r.rdy = rdy; r.crst = crst; r.we = we; r.addr = a; r.wdata = wd;
    r.busy = b; r.done = dn; r.abort = ab; r.ovf = ov; r.cnt = c;
    return r;
  endfunction

  function automatic out_t sample();
    return outp(dbgState, ld_ready, cpu_reset, mem_we, mem_addr, mem_wdata,
                busy, done, abort, overflow, cycle_count);
  endfunction

  function automatic in_t idle();
    return inp(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  // Driver: move to the next falling edge, drive inputs, let them settle
  task automatic apply(input in_t v);
    @(negedge clk);
    start       = v.start;
    ld_valid    = v.ldValid;
    ld_data     = v.ldData;
    ld_last     = v.ldLast;
    cpu_memadd  = v.cpuMemadd;
    cpu_outdata = v.cpuOutdata;
    cpu_we      = v.cpuWe;
    cpu_stop    = v.cpuStop;
    #1;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got st=%0d rdy=%0b crst=%0b we=%0b addr=%h wdata=%h busy=%0b done=%0b abort=%0b ovf=%0b cnt=%0d; expected st=%0d rdy=%0b crst=%0b we=%0b addr=%h wdata=%h busy=%0b done=%0b abort=%0b ovf=%0b cnt=%0d",
               name, act.st, act.rdy, act.crst, act.we, act.addr, act.wdata, act.busy,
               act.done, act.abort, act.ovf, act.cnt, exp.st, exp.rdy, exp.crst, exp.we,
               exp.addr, exp.wdata, exp.busy, exp.done, exp.abort, exp.ovf, exp.cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare logged writes against the expected queue
  task automatic drain(input string name);
    logic [63:0] got;
    logic [63:0] want;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      testsRun++;
      if (wr_q.size() == 0) begin
        testsFailed++;
        $display("FAIL %s_write: got no write, expected addr=%h data=%h",
                 name, want[63:32], want[31:0]);
      end else begin
        got = wr_q.pop_front();
        if (got !== want) begin
          testsFailed++;
          $display("FAIL %s_write: got addr=%h data=%h, expected addr=%h data=%h",
                   name, got[63:32], got[31:0], want[63:32], want[31:0]);
        end
      end
    end
    check_val({name, "_extra_writes"}, 64'(wr_q.size()), 64'd0);
    wr_q.delete();
  endtask

  initial begin
    int  holdCycles;
    logic reachedRun;

    testsRun = 0;
    testsFailed = 0;

    // Per-cycle vectors: values checked before the rising edge of that cycle.
    // Session 1: 3-word image, run, stop. Session 2: overflow with MEM_WORDS=4.
    vecs[0]  = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_IDLE,0,1,0,32'h0,32'h0,0,0,0,0,0)};
    vecs[1]  = '{inp(1,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_IDLE,0,1,0,32'h0,32'h0,0,0,0,0,0)};
    vecs[2]  = '{inp(1,1,32'h20020005,0,32'h0,32'h0,0,0),   outp(ST_LOAD,1,1,1,32'h0,32'h20020005,1,0,0,0,0)};
    vecs[3]  = '{inp(0,1,32'h20030007,0,32'h0,32'h0,0,0),   outp(ST_LOAD,1,1,1,32'h4,32'h20030007,1,0,0,0,0)};
    vecs[4]  = '{inp(0,1,32'hFC00003F,1,32'h0,32'h0,0,0),   outp(ST_LOAD,1,1,1,32'h8,32'hFC00003F,1,0,0,0,0)};
    vecs[5]  = '{inp(0,1,32'h55,0,32'h0,32'h0,0,0),         outp(ST_HOLD,0,1,0,32'h0,32'h0,1,0,0,0,0)};
    vecs[6]  = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_HOLD,0,1,0,32'h0,32'h0,1,0,0,0,0)};
    vecs[7]  = '{inp(1,0,32'h0,0,32'h10,32'hAB,1,0),        outp(ST_RUN,0,0,1,32'h10,32'hAB,1,0,0,0,0)};
    vecs[8]  = '{inp(0,0,32'h0,0,32'h4,32'h0,0,0),          outp(ST_RUN,0,0,0,32'h4,32'h0,1,0,0,0,1)};
    vecs[9]  = '{inp(0,0,32'h0,0,32'h0,32'h0,0,1),          outp(ST_RUN,0,0,0,32'h0,32'h0,1,0,0,0,2)};
    vecs[10] = '{inp(0,0,32'h0,0,32'h10,32'hCD,1,0),        outp(ST_HALT,0,1,0,32'h0,32'h0,0,1,0,0,3)};
    vecs[11] = '{inp(1,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_HALT,0,1,0,32'h0,32'h0,0,1,0,0,3)};
    vecs[12] = '{inp(0,1,32'hA0,0,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,1,32'h0,32'hA0,1,0,0,0,0)};
    vecs[13] = '{inp(0,1,32'hA1,0,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,1,32'h4,32'hA1,1,0,0,0,0)};
    vecs[14] = '{inp(0,1,32'hA2,0,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,1,32'h8,32'hA2,1,0,0,0,0)};
    vecs[15] = '{inp(0,1,32'hA3,0,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,1,32'hC,32'hA3,1,0,0,0,0)};
    vecs[16] = '{inp(0,1,32'hA4,0,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,0,32'hC,32'hA4,1,0,0,1,0)};
    vecs[17] = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_LOAD,1,1,0,32'hC,32'h0,1,0,0,1,0)};
    vecs[18] = '{inp(0,1,32'hA5,1,32'h0,32'h0,0,0),         outp(ST_LOAD,1,1,0,32'hC,32'hA5,1,0,0,1,0)};
    vecs[19] = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_HOLD,0,1,0,32'h0,32'h0,1,0,0,1,0)};
    vecs[20] = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_HOLD,0,1,0,32'h0,32'h0,1,0,0,1,0)};
    vecs[21] = '{inp(0,0,32'h0,0,32'h0,32'h0,0,0),          outp(ST_RUN,0,0,0,32'h0,32'h0,1,0,0,1,0)};

    // Reset
    start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    cpu_memadd = '0; cpu_outdata = '0; cpu_we = 0; cpu_stop = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    check_out("reset_state", outp(ST_IDLE,0,1,0,32'h0,32'h0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b1;

    // Table-driven sessions
    for (int k = 0; k < NVEC; k++) begin
      apply(vecs[k].i);
      check_out($sformatf("vec%0d", k), vecs[k].o);
    end

    // Timeout: the table left the core in its first RUN cycle (count 0)
    for (int i = 1; i <= 49; i++) begin
      apply(inp((i == 10), 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
      check_val($sformatf("timeout_run%0d", i), {32'(dbgState), cycle_count}, {32'(ST_RUN), 32'(i)});
    end
    apply(inp(0, 0, 32'h0, 0, 32'h40, 32'h99, 1, 0));
    check_out("timeout_abort", outp(ST_ABORT,0,1,0,32'h0,32'h0,0,0,1,1,50));
    apply(inp(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    apply(idle());
    check_out("restart_clears", outp(ST_LOAD,1,1,0,32'h0,32'h0,1,0,0,0,0));

    exp_q.push_back({32'h0, 32'h20020005});
    exp_q.push_back({32'h4, 32'h20030007});
    exp_q.push_back({32'h8, 32'hFC00003F});
    exp_q.push_back({32'h10, 32'hAB});
    exp_q.push_back({32'h0, 32'hA0});
    exp_q.push_back({32'h4, 32'hA1});
    exp_q.push_back({32'h8, 32'hA2});
    exp_q.push_back({32'hC, 32'hA3});
    drain("table");

    // Loader with gaps: a word every third cycle, start pulse ignored in LOAD
    for (int c = 0; c < 9; c++) begin
      apply(inp((c == 4), (c % 3 == 2), 32'h100 + 32'(c), (c == 8), 32'h0, 32'h0, 0, 0));
      check_val($sformatf("gap_ready%0d", c), {61'(dbgState), ld_ready}, {61'(ST_LOAD), 1'b1});
      if (c % 3 == 2) exp_q.push_back({32'(4 * (c / 3)), 32'h100 + 32'(c)});
    end
    holdCycles = 0;
    reachedRun = 1'b0;
    for (int k = 0; k < 10 && !reachedRun; k++) begin
      apply(idle());
      if (dbgState == ST_RUN) reachedRun = 1'b1;
      else if (dbgState == ST_HOLD) holdCycles++;
    end
    check_val("gap_reached_run", 64'(reachedRun), 64'd1);
    check_val("gap_hold_cycles", 64'(holdCycles), 64'd2);

    // Stop on the same edge as the timeout: completion wins
    for (int i = 0; i <= 49; i++) begin
      if (i > 0) apply(inp(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, (i == 49)));
      if (i % 7 == 0 || i == 49)
        check_val($sformatf("stop_run%0d", i), {32'(dbgState), cycle_count}, {32'(ST_RUN), 32'(i)});
    end
    apply(idle());
    check_out("stop_at_timeout", outp(ST_HALT,0,1,0,32'h0,32'h0,0,1,0,0,50));
    drain("gap");

    // Reset in the middle of RUN while the core is writing
    apply(inp(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    apply(inp(0, 1, 32'h200, 1, 32'h0, 32'h0, 0, 0));
    check_val("mid_load", 64'(dbgState), 64'(ST_LOAD));
    apply(idle());
    apply(idle());
    apply(idle());
    check_val("mid_run0", {32'(dbgState), cycle_count}, {32'(ST_RUN), 32'd0});
    apply(inp(0, 0, 32'h0, 0, 32'h30, 32'h77, 1, 0));
    check_val("mid_passthru_we", {31'(mem_addr), mem_we}, {31'h30, 1'b1});
    #1 reset = 1'b0;
    #1;
    check_out("mid_reset", outp(ST_IDLE,0,1,0,32'h0,32'h0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back({32'h0, 32'h200});

    // Clean session after the reset
    apply(inp(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    apply(inp(0, 1, 32'h300, 0, 32'h0, 32'h0, 0, 0));
    apply(inp(0, 1, 32'h301, 1, 32'h0, 32'h0, 0, 0));
    check_out("clean_load2", outp(ST_LOAD,1,1,1,32'h4,32'h301,1,0,0,0,0));
    apply(idle());
    apply(idle());
    apply(idle());
    apply(idle());
    apply(inp(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1));
    check_val("clean_run2", {32'(dbgState), cycle_count}, {32'(ST_RUN), 32'd2});
    apply(idle());
    check_out("clean_halt", outp(ST_HALT,0,1,0,32'h0,32'h0,0,1,0,0,3));
    exp_q.push_back({32'h0, 32'h300});
    exp_q.push_back({32'h4, 32'h301});
    drain("reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Top-level sequencer for the multicycle MIPS datapath and its single-port program/data memory. It streams a program image into memory over a valid/ready loader port while holding the core in reset. It then releases the core, runs it until the core raises its stop flag or a cycle budget expires, and reports status and cycle count. It owns the memory port mux between the loader and the core.

Parameters:
MEM_WORDS, 256, memory depth in 32-bit words; loader may write word indices 0..MEM_WORDS-1
RST_HOLD, 2, cycles the core reset is held after loading before the run starts (min 1)
TIMEOUT, 100000, maximum RUN cycles before forced abort
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load+run session from IDLE, HALT or ABORT
ld_valid  in  1  loader word valid
ld_data  in  32  loader word
ld_last  in  1  marks final word of image (qualified by ld_valid)
ld_ready  out  1  controller accepts loader word
cpu_reset  out  1  active-high synchronous reset to datapath
cpu_memadd  in  32  datapath memory byte address
cpu_outdata  in  32  datapath store data
cpu_we  in  1  datapath write enable
cpu_stop  in  1  datapath END-instruction flag
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_we  out  1  memory write enable
busy  out  1  high in LOAD, HOLD, RUN
done  out  1  high in HALT (normal completion)
abort  out  1  high in ABORT
overflow  out  1  sticky: loader attempted write past MEM_WORDS-1; cleared on start
cycle_count  out  CNT_W  RUN cycles of current/last session

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_reset=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, abort=0, overflow=0, cycle_count=0, load pointer=0. Mid-session reset abandons the session immediately.
- States: IDLE, LOAD, HOLD, RUN, HALT, ABORT. State and all outputs are registered or decoded from registered state; no combinational path from loader inputs to ld_ready.
- IDLE/HALT/ABORT: cpu_reset=1, mem_we=0. start -> LOAD. On that edge: load pointer=0, cycle_count=0, overflow=0, done/abort drop.
- LOAD: ld_ready=1, cpu_reset=1. Transfer = ld_valid&&ld_ready. mem_addr={ptr,2'b00} (byte address, word i at 4*i), mem_wdata=ld_data, mem_we=transfer, all combinational from pointer/inputs. ptr increments per transfer. If transfer with ptr==MEM_WORDS-1 and !ld_last: word written, ptr saturates, overflow=1; later words are accepted and dropped (mem_we=0). Transfer with ld_last -> HOLD. start ignored.
- HOLD: cpu_reset=1, ld_ready=0, mem_we=0. Held exactly RST_HOLD cycles, then RUN.
- RUN: cpu_reset=0; mem_addr=cpu_memadd, mem_wdata=cpu_outdata, mem_we=cpu_we (pure pass-through). cycle_count increments every RUN cycle, first RUN cycle leaves it at 1. cpu_stop=1 -> HALT, that cycle counted. Else if cycle_count==TIMEOUT-1 at the edge -> ABORT, count ends at TIMEOUT. cpu_stop and timeout on the same edge: HALT wins. start ignored.
- HALT/ABORT: core re-held in reset so END is not re-executed; cycle_count frozen until next start.
- ld_ready is 0 outside LOAD; loader words offered outside LOAD are not consumed.

Test Plan:
- Load 3 words (0x20020005, 0x20030007, 0xFC00003F with ld_last), ld_valid held high -> mem_we pulses at addr 0,4,8; HOLD 2 cycles; RUN; core stops; done=1, registers $2=5, $3=7, cycle_count equals measured RUN cycles.
- Loader with ld_valid gaps (valid every 3rd cycle) -> exactly 3 writes, addresses 0,4,8, no duplicates, ld_ready stays 1 in LOAD.
- Image with no END (infinite j loop), TIMEOUT=50 -> ABORT after exactly 50 RUN cycles, cycle_count=50, cpu_reset=1, mem_we=0 afterwards.
- MEM_WORDS=4, send 6 words, last flagged -> writes only at 0,4,8,12; overflow=1; reaches RUN; next start clears overflow.
- Assert reset low mid-RUN on a cycle where cpu_we=1 -> same cycle mem_we=0, cpu_reset=1, state IDLE; start afterwards runs a clean session.
- start pulses during LOAD and RUN -> ignored; cpu_stop coinciding with timeout edge -> done=1, abort=0.
